alu_step_sequencer: RTL and testbench
=====================================

Name: alu_step_sequencer

Overview:
- Parametrised control sequencer for register-register ALU instructions.
- Drives the datapath's encoded enable/bus-select codes, memory read, PC increment and ALU op through fetch (T0–T2) and execute (T3–T5).
- Adds three capabilities:
  - memory-ready stall with timeout in T1;
  - instruction decode from the IR word, with illegal and halt detection;
  - continuous run mode.

Parameters:
- DATA_W, 32, IR/data width.
- REG_AW, 4, register index width (2**REG_AW GPRs, codes 0..2**REG_AW-1).
- OPC_W, 5, opcode width; IR field layout: opcode [DATA_W-1 -: OPC_W], ra/rb/rc in the next three REG_AW fields.
- SEL_W, 5, width of enable/bus-select codes.
- MEM_TIMEOUT, 15, maximum T1 wait cycles before fault.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  begin an instruction from IDLE.
- run_mode  in  1  when 1, T5 chains directly to T0.
- mem_ready  in  1  memory data valid on MDataIn.
- ir_in  in  DATA_W  IR register contents, sampled in T3.
- enable_code  out  SEL_W  register-load select; 0 = none.
- bus_select_code  out  SEL_W  bus driver select; 0 = none.
- mr_read  out  1  memory read strobe.
- pc_inc  out  1  PC increment.
- alu_op  out  4  ALU control; 0 = idle.
- busy  out  1  high in T0..T5.
- done  out  1  one-cycle pulse at the end of T5.
- fault  out  1  one-cycle pulse on illegal opcode or memory timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0, latched fields 0. Reset is asynchronous and overrides everything, including mid-instruction; state returns to IDLE with no completion pulse.
- Outputs are registered from the next state. The values listed per state are valid for that entire cycle.
- IDLE: all outputs 0. Goes to T0 when start=1.
- T0: bus_select_code=PC(20), enable_code=MAR(25), pc_inc=1. Next T1.
- T1: mr_read=1, enable_code=MDR(21).
  - Stays in T1 while mem_ready=0, incrementing the wait counter.
  - mem_ready=1: go to T2, counter cleared.
  - Counter reaches MEM_TIMEOUT with mem_ready=0: go to FAULT.
  - mem_ready=1 on the timeout cycle: go to T2 (ready wins).
- T2: bus_select_code=MDR(21), enable_code=IR(23). Next T3.
- T3: decode ir_in and latch opcode, ra, rb, rc.
  - Illegal opcode: go to FAULT; this cycle drives no outputs.
  - HALT(5'd31): go to IDLE; this cycle drives no outputs.
  - Otherwise: bus_select_code=rb, enable_code=Y(27). Next T4.
- T4: bus_select_code=rc, enable_code=Z(24), alu_op=decoded op. Next T5.
- T5: bus_select_code=ZLO(19), enable_code=ra, done=1.
  - run_mode=1: next T0.
  - run_mode=0: next IDLE.
- FAULT: fault=1 for one cycle, all other outputs 0. Next IDLE.
- Opcode map (opcode→alu_op): ADD 3→1, SUB 4→2, AND 5→3, OR 6→4, SHR 7→5, SHL 8→6, ROR 9→7, ROL 10→8. All others illegal except HALT.
- start is ignored outside IDLE. run_mode is sampled only in T5.
- Register index outputs are zero-extended from REG_AW to SEL_W. Elaboration check: 2**REG_AW <= 19.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum (IDLE, T0..T5, FAULT);
  - datapath code constants (ZLO=19, PC=20, MDR=21, IR=23, Z=24, MAR=25, Y=27);
  - opcode and alu_op localparams.
- One sub-module: alu_seq_decode. It is combinational: opcode to alu_op, with illegal and halt flags.

Test Plan:
- clr=1 mid-T4 (alu_op=1) → all outputs 0 within the same cycle; IDLE after release; no done pulse.
- start, mem_ready=1 in T1, ir_in=0x18A28000 (ADD ra=1, rb=4, rc=5) → sequence T0(20/25, pc_inc), T1(mr_read), T2(21/23), T3(bus 4/en 27), T4(bus 5/en 24, alu_op=1), T5(bus 19/en 1, done) → done exactly 6 cycles after start sampled.
- mem_ready held 0 for 5 cycles then 1 → T1 lasts 6 cycles, no fault, done 5 cycles later than the previous case.
- mem_ready held 0 → fault pulse after 15 wait cycles, then IDLE, mr_read drops to 0.
- ir_in opcode 5'd0 → fault pulse after T3, no Y/Z enables, back to IDLE.
- run_mode=1 with ADD then HALT(0xF8000000) → second T0 follows T5 immediately; HALT returns to IDLE with busy=0 and no fault.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU step sequencer.
// Holds the state enum, datapath enable/bus-select codes and the opcode-to-alu_op map.
// Contents: state_e, SEL_* codes, OPC_* opcodes, ALU_* controls, MAX_GPRS.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_T0    = 3'd1,
    ST_T1    = 3'd2,
    ST_T2    = 3'd3,
    ST_T3    = 3'd4,
    ST_T4    = 3'd5,
    ST_T5    = 3'd6,
    ST_FAULT = 3'd7
  } state_e;

  // Datapath enable / bus-select codes. GPRs occupy codes 0..MAX_GPRS-1,
  // so the special registers start just above them.
  localparam int unsigned SEL_NONE = 0;
  localparam int unsigned SEL_ZLO  = 19;
  localparam int unsigned SEL_PC   = 20;
  localparam int unsigned SEL_MDR  = 21;
  localparam int unsigned SEL_IR   = 23;
  localparam int unsigned SEL_Z    = 24;
  localparam int unsigned SEL_MAR  = 25;
  localparam int unsigned SEL_Y    = 27;

  localparam int unsigned MAX_GPRS = 19;

  // Instruction opcodes.
  localparam int unsigned OPC_ADD  = 3;
  localparam int unsigned OPC_SUB  = 4;
  localparam int unsigned OPC_AND  = 5;
  localparam int unsigned OPC_OR   = 6;
  localparam int unsigned OPC_SHR  = 7;
  localparam int unsigned OPC_SHL  = 8;
  localparam int unsigned OPC_ROR  = 9;
  localparam int unsigned OPC_ROL  = 10;
  localparam int unsigned OPC_HALT = 31;

  // ALU control values; 0 leaves the ALU idle.
  localparam logic [3:0] ALU_IDLE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;

endpackage

// File: rtl/alu_seq_decode.sv
// Opcode decoder: maps an instruction opcode to its ALU control, flags HALT and illegal codes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the input in the same cycle.
// Ports: opcode (in, OPC_W), alu_op (out, 4), illegal (out), halt (out).
module alu_seq_decode #(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode,
  output logic [3:0]       alu_op,
  output logic             illegal,
  output logic             halt
);
  import alu_seq_pkg::*;

  always_comb begin
    alu_op  = ALU_IDLE;
    illegal = 1'b0;
    halt    = 1'b0;
    case (opcode)
      OPC_W'(OPC_ADD):  alu_op = ALU_ADD;
      OPC_W'(OPC_SUB):  alu_op = ALU_SUB;
      OPC_W'(OPC_AND):  alu_op = ALU_AND;
      OPC_W'(OPC_OR):   alu_op = ALU_OR;
      OPC_W'(OPC_SHR):  alu_op = ALU_SHR;
      OPC_W'(OPC_SHL):  alu_op = ALU_SHL;
      OPC_W'(OPC_ROR):  alu_op = ALU_ROR;
      OPC_W'(OPC_ROL):  alu_op = ALU_ROL;
      OPC_W'(OPC_HALT): halt   = 1'b1;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Control sequencer for register-register ALU instructions: fetch T0-T2, execute T3-T5.
// Latency: outputs registered from next state; done asserts in the 6th cycle after start when memory is ready at once.
// Backpressure: T1 holds while mem_ready=0 and faults after MEM_TIMEOUT wait cycles; start ignored when not IDLE.
// Ports: clk, clr (async high reset), start, run_mode, mem_ready, ir_in[DATA_W] in;
//        enable_code/bus_select_code[SEL_W], mr_read, pc_inc, alu_op[4], busy, done, fault out.
module alu_step_sequencer #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int OPC_W       = 5,
  parameter int SEL_W       = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              run_mode,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] ir_in,
  output logic [SEL_W-1:0]  enable_code,
  output logic [SEL_W-1:0]  bus_select_code,
  output logic              mr_read,
  output logic              pc_inc,
  output logic [3:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic              fault
);
  import alu_seq_pkg::*;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int LOW_W = DATA_W - OPC_W - 3 * REG_AW;

  // Register codes must not collide with the special datapath codes.
  if ((2 ** REG_AW) > MAX_GPRS) begin : g_chk_gprs
    $error("alu_step_sequencer: 2**REG_AW must not exceed %0d", MAX_GPRS);
  end
  if (REG_AW > SEL_W) begin : g_chk_sel
    $error("alu_step_sequencer: REG_AW must not exceed SEL_W");
  end
  if (LOW_W < 0) begin : g_chk_ir
    $error("alu_step_sequencer: IR fields do not fit in DATA_W");
  end

  // IR field extraction.
  logic [OPC_W-1:0]  ir_opc;
  logic [REG_AW-1:0] ir_ra, ir_rb, ir_rc;
  assign ir_opc = ir_in[DATA_W-1 -: OPC_W];
  assign ir_ra  = ir_in[DATA_W-OPC_W-1 -: REG_AW];
  assign ir_rb  = ir_in[DATA_W-OPC_W-REG_AW-1 -: REG_AW];
  assign ir_rc  = ir_in[DATA_W-OPC_W-2*REG_AW-1 -: REG_AW];

  if (LOW_W > 0) begin : g_low
    logic unused_ir_low;
    assign unused_ir_low = ^ir_in[LOW_W-1:0];
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [REG_AW-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

  logic [SEL_W-1:0]  enable_code_q, enable_code_d;
  logic [SEL_W-1:0]  bus_select_code_q, bus_select_code_d;
  logic              mr_read_q, mr_read_d;
  logic              pc_inc_q, pc_inc_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic [3:0]        dec_alu_op;
  logic              dec_illegal, dec_halt;

  // The IR fields are captured on the edge that enters T3, so T3's own
  // registered outputs can already carry rb. Outside that edge the latched
  // copy is held and fed to the decoder.
  always_comb begin
    opc_d = opc_q;
    ra_d  = ra_q;
    rb_d  = rb_q;
    rc_d  = rc_q;
    if (state_q == ST_T2) begin
      opc_d = ir_opc;
      ra_d  = ir_ra;
      rb_d  = ir_rb;
      rc_d  = ir_rc;
    end
  end

  alu_seq_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .opcode  (opc_d),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal),
    .halt    (dec_halt)
  );

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_T0;
      ST_T0: begin
        state_d    = ST_T1;
        wait_cnt_d = '0;
      end
      ST_T1: begin
        if (mem_ready) begin
          // Ready wins even on the cycle the counter would time out.
          state_d    = ST_T2;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_d == CNT_W'(MEM_TIMEOUT)) begin
            state_d    = ST_FAULT;
            wait_cnt_d = '0;
          end
        end
      end
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        if (dec_illegal)   state_d = ST_FAULT;
        else if (dec_halt) state_d = ST_IDLE;
        else               state_d = ST_T4;
      end
      ST_T4:    state_d = ST_T5;
      ST_T5:    state_d = run_mode ? ST_T0 : ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    enable_code_d     = SEL_W'(SEL_NONE);
    bus_select_code_d = SEL_W'(SEL_NONE);
    mr_read_d         = 1'b0;
    pc_inc_d          = 1'b0;
    alu_op_d          = ALU_IDLE;
    busy_d            = 1'b0;
    done_d            = 1'b0;
    fault_d           = 1'b0;
    case (state_d)
      ST_T0: begin
        bus_select_code_d = SEL_W'(SEL_PC);
        enable_code_d     = SEL_W'(SEL_MAR);
        pc_inc_d          = 1'b1;
        busy_d            = 1'b1;
      end
      ST_T1: begin
        mr_read_d     = 1'b1;
        enable_code_d = SEL_W'(SEL_MDR);
        busy_d        = 1'b1;
      end
      ST_T2: begin
        bus_select_code_d = SEL_W'(SEL_MDR);
        enable_code_d     = SEL_W'(SEL_IR);
        busy_d            = 1'b1;
      end
      ST_T3: begin
        busy_d = 1'b1;
        // HALT and illegal codes leave the datapath untouched in T3.
        if (!dec_illegal && !dec_halt) begin
          bus_select_code_d = SEL_W'(rb_d);
          enable_code_d     = SEL_W'(SEL_Y);
        end
      end
      ST_T4: begin
        bus_select_code_d = SEL_W'(rc_q);
        enable_code_d     = SEL_W'(SEL_Z);
        alu_op_d          = dec_alu_op;
        busy_d            = 1'b1;
      end
      ST_T5: begin
        bus_select_code_d = SEL_W'(SEL_ZLO);
        enable_code_d     = SEL_W'(ra_q);
        done_d            = 1'b1;
        busy_d            = 1'b1;
      end
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q           <= ST_IDLE;
      wait_cnt_q        <= '0;
      opc_q             <= '0;
      ra_q              <= '0;
      rb_q              <= '0;
      rc_q              <= '0;
      enable_code_q     <= '0;
      bus_select_code_q <= '0;
      mr_read_q         <= 1'b0;
      pc_inc_q          <= 1'b0;
      alu_op_q          <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      fault_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      wait_cnt_q        <= wait_cnt_d;
      opc_q             <= opc_d;
      ra_q              <= ra_d;
      rb_q              <= rb_d;
      rc_q              <= rc_d;
      enable_code_q     <= enable_code_d;
      bus_select_code_q <= bus_select_code_d;
      mr_read_q         <= mr_read_d;
      pc_inc_q          <= pc_inc_d;
      alu_op_q          <= alu_op_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      fault_q           <= fault_d;
    end
  end

  assign enable_code     = enable_code_q;
  assign bus_select_code = bus_select_code_q;
  assign mr_read         = mr_read_q;
  assign pc_inc          = pc_inc_q;
  assign alu_op          = alu_op_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Self-checking bench for alu_step_sequencer: directed instructions against a per-cycle expectation queue.
// The model lists, per instruction, the output vector of each cycle from the phase rules and opcode table.
// Literal latency/count checks pin the model and the DUT timing.
module tb_alu_step_sequencer;

  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        run_mode;
  logic        mem_ready;
  logic [31:0] ir_in;
  logic [4:0]  enable_code;
  logic [4:0]  bus_select_code;
  logic        mr_read;
  logic        pc_inc;
  logic [3:0]  alu_op;
  logic        busy;
  logic        done;
  logic        fault;

  alu_step_sequencer #(
    .DATA_W      (32),
    .REG_AW      (4),
    .OPC_W       (5),
    .SEL_W       (5),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk             (clk),
    .clr             (clr),
    .start           (start),
    .run_mode        (run_mode),
    .mem_ready       (mem_ready),
    .ir_in           (ir_in),
    .enable_code     (enable_code),
    .bus_select_code (bus_select_code),
    .mr_read         (mr_read),
    .pc_inc          (pc_inc),
    .alu_op          (alu_op),
    .busy            (busy),
    .done            (done),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] en;
    logic [4:0] bus;
    logic       mr;
    logic       pc;
    logic [3:0] alu;
    logic       bsy;
    logic       dn;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   chk_en  = 1'b0;
  bit   ready_map [0:4095];
  int   last_done  = -1;
  int   last_fault = -1;
  int   n_done     = 0;

  logic [18:0] dut_vec;
  assign dut_vec = {enable_code, bus_select_code, mr_read, pc_inc, alu_op, busy, done, fault};

  function automatic logic [18:0] pack(input exp_t e);
    return {e.en, e.bus, e.mr, e.pc, e.alu, e.bsy, e.dn, e.flt};
  endfunction

  function automatic exp_t rec(input int c, input int en, input int bus, input bit mr, input bit pc,
                               input int alu, input bit bsy, input bit dn, input bit flt);
    exp_t r;
    r.cyc = c;
    r.en  = 5'(en);
    r.bus = 5'(bus);
    r.mr  = mr;
    r.pc  = pc;
    r.alu = 4'(alu);
    r.bsy = bsy;
    r.dn  = dn;
    r.flt = flt;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Behavioural model: the per-cycle output list of one instruction whose
  // first (T0) cycle is 'base'. w = cycles memory stays not-ready in T1.
  task automatic model_instr(input logic [31:0] ir, input int w, input int base,
                             output int next_free, output bit completes);
    int c, opc, ra, rb, rc;
    c   = base;
    opc = int'(ir[31:27]);
    ra  = int'(ir[26:23]);
    rb  = int'(ir[22:19]);
    rc  = int'(ir[18:15]);
    completes = 1'b0;
    exp_q.push_back(rec(c, 25, 20, 0, 1, 0, 1, 0, 0)); c++;
    if (w >= MEM_TIMEOUT) begin
      repeat (MEM_TIMEOUT) begin
        exp_q.push_back(rec(c, 21, 0, 1, 0, 0, 1, 0, 0)); c++;
      end
      exp_q.push_back(rec(c, 0, 0, 0, 0, 0, 0, 0, 1)); c++;
    end else begin
      repeat (w + 1) begin
        exp_q.push_back(rec(c, 21, 0, 1, 0, 0, 1, 0, 0)); c++;
      end
      exp_q.push_back(rec(c, 23, 21, 0, 0, 0, 1, 0, 0)); c++;
      if (opc == 31) begin
        exp_q.push_back(rec(c, 0, 0, 0, 0, 0, 1, 0, 0)); c++;
      end else if (opc < 3 || opc > 10) begin
        exp_q.push_back(rec(c, 0, 0, 0, 0, 0, 1, 0, 0)); c++;
        exp_q.push_back(rec(c, 0, 0, 0, 0, 0, 0, 0, 1)); c++;
      end else begin
        exp_q.push_back(rec(c, 27, rb, 0, 0, 0, 1, 0, 0)); c++;
        exp_q.push_back(rec(c, 24, rc, 0, 0, opc - 2, 1, 0, 0)); c++;
        exp_q.push_back(rec(c, ra, 19, 0, 0, 0, 1, 1, 0)); c++;
        completes = 1'b1;
      end
    end
    next_free = c;
  endtask

  // Cycle counter and memory-ready driver.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1 mem_ready = (cyc < 4096) ? ready_map[cyc] : 1'b0;
    end
  end

  // Per-cycle comparison against the model queue; idle expected when no record is due.
  initial begin
    forever begin : cmp_blk
      exp_t e;
      @(negedge clk);
      if (chk_en) begin
        e = rec(cyc, 0, 0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL stale_record: record for cycle %0d not compared, now cycle %0d", exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
        n_tests++;
        if (dut_vec !== pack(e)) begin
          n_fail++;
          $display("FAIL cycle_%0d: got en=%0d bus=%0d mr=%b pc=%b alu=%0d busy=%b done=%b fault=%b, required en=%0d bus=%0d mr=%b pc=%b alu=%0d busy=%b done=%b fault=%b",
                   cyc, enable_code, bus_select_code, mr_read, pc_inc, alu_op, busy, done, fault,
                   e.en, e.bus, e.mr, e.pc, e.alu, e.bsy, e.dn, e.flt);
        end
      end
    end
  end

  // Pulse monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        last_done = cyc;
        n_done++;
      end
      if (fault === 1'b1) last_fault = cyc;
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Raise start for one edge; c is the cycle number in which start was presented.
  task automatic launch(input logic [31:0] ir, input int w, input bit rm, output int c);
    @(negedge clk);
    c          = cyc;
    last_done  = -1;
    last_fault = -1;
    n_done     = 0;
    if (w < MEM_TIMEOUT) ready_map[c + 2 + w] = 1'b1;
    ir_in    = ir;
    run_mode = rm;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic single(input string tag, input logic [31:0] ir, input int w,
                        input int done_lat, input int fault_lat);
    int c, nf;
    bit ok;
    launch(ir, w, 1'b0, c);
    model_instr(ir, w, c + 1, nf, ok);
    wait_until(nf + 2);
    check({tag, "_done_lat"},  (last_done  < 0) ? -1 : last_done  - c, done_lat);
    check({tag, "_fault_lat"}, (last_fault < 0) ? -1 : last_fault - c, fault_lat);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int c, nf, nf2;
    bit ok, ok2;
    logic [31:0] ir_add, ir_halt, ir_ill0, ir_ill11, ir_rol;
    ir_add   = 32'h18A2_8000;
    ir_halt  = 32'hF800_0000;
    ir_ill0  = 32'h00A2_8000;
    ir_ill11 = {5'd11, 4'd2, 4'd3, 4'd4, 15'd0};
    ir_rol   = {5'd10, 4'd15, 4'd0, 4'd9, 15'd0};

    clr = 1'b1; start = 1'b0; run_mode = 1'b0; mem_ready = 1'b0; ir_in = '0;
    #3 check("reset_outputs", int'(dut_vec), 0);
    @(negedge clk);
    clr    = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // ADD r1 = r4 + r5, memory ready at once; pin the model on this case.
    launch(ir_add, 0, 1'b0, c);
    model_instr(ir_add, 0, c + 1, nf, ok);
    check("model_add_len", nf - c, 7);
    check("model_add_t4_alu", int'(exp_q[4].alu), 1);
    check("model_add_t5_en", int'(exp_q[5].en), 1);
    check("model_add_t3_bus", int'(exp_q[3].bus), 4);
    wait_until(nf + 2);
    check("add_done_lat", last_done - c, 6);
    check("add_done_count", n_done, 1);
    check("add_no_fault", last_fault, -1);

    // Memory stalls: 5 wait cycles, then the last wait before timeout (ready wins).
    single("add_w5",  ir_add, 5,  11, -1);
    single("add_w14", ir_add, 14, 20, -1);
    // Memory never ready: fault after 15 wait cycles.
    single("timeout", ir_add, MEM_TIMEOUT, -1, 17);
    // Illegal opcodes at both ends of the legal range's neighbourhood.
    single("illegal0",  ir_ill0,  0, -1, 5);
    single("illegal11", ir_ill11, 0, -1, 5);
    // ROL with ra=15, rb=0, rc=9.
    single("rol", ir_rol, 2, 8, -1);

    // Run mode: ADD chains into HALT without a start pulse.
    launch(ir_add, 0, 1'b1, c);
    model_instr(ir_add, 0, c + 1, nf, ok);
    model_instr(ir_halt, 0, nf, nf2, ok2);
    ready_map[nf + 1] = 1'b1;
    check("model_chain_end", nf2 - c, 11);
    wait_until(c + 6);
    ir_in = ir_halt;
    wait_until(c + 7);
    run_mode = 1'b0;
    wait_until(nf2 + 2);
    check("chain_done_lat", last_done - c, 6);
    check("chain_done_count", n_done, 1);
    check("chain_no_fault", last_fault, -1);
    check("chain_queue_left", exp_q.size(), 0);

    // Asynchronous reset in the middle of T4.
    chk_en = 1'b0;
    launch(ir_add, 0, 1'b0, c);
    wait_until(c + 5);
    check("pre_reset_alu_op", int'(alu_op), 1);
    clr = 1'b1;
    #1 check("reset_mid_t4_outputs", int'(dut_vec), 0);
    @(negedge clk);
    clr    = 1'b0;
    chk_en = 1'b1;
    wait_until(c + 12);
    check("reset_no_done", n_done, 0);
    check("reset_no_fault", last_fault, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
